// File: rtl/komut_issue_ctrl_if.sv
// Bus bundle between the fetch/issue sequencer and its neighbours:
// instruction memory (req/ack), decoder (komut/dec_hata), execute stage
// (issue valid/ready) and the branch redirect path from execute.
interface komut_issue_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] komut;
    logic        dec_hata;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, komut, issue_valid, issue_pc,
        input  imem_ack, imem_rdata, dec_hata, issue_ready, redir_valid, redir_pc
    );

    // Environment side (memory, decoder, execute)
    modport slave (
        input  imem_req, imem_addr, komut, issue_valid, issue_pc,
        output imem_ack, imem_rdata, dec_hata, issue_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/komut_issue_ctrl.sv
// Fetch/issue sequencer in front of the command decoder. Holds the pc,
// fetches 32-bit commands over req/ack, waits out the decoder latency,
// checks the illegal-opcode flag and issues good commands to execute.
// Optional memory-timeout watchdog: define MEM_TIMEOUT_EN.
module komut_issue_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          DEC_LAT     = 2,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    komut_issue_ctrl_if.master  bus,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          err_code,
    output logic [31:0]         instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_HALT
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(DEC_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] komut_q, komut_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        gap_q, gap_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] redir_word;
    logic        fetch_req;

`ifdef MEM_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^MEM_TIMEOUT;
`endif

    assign redir_word = {bus.redir_pc[31:2], 2'b00};
    assign fetch_req  = (state_q == ST_FETCH) && !gap_q;

    assign bus.imem_req    = fetch_req;
    assign bus.imem_addr   = pc_q;
    assign bus.komut       = komut_q;
    assign bus.issue_valid = (state_q == ST_ISSUE);
    assign bus.issue_pc    = pc_q;
    assign busy            = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted          = (state_q == ST_HALT);
    assign err_code        = err_code_q;
    assign instr_count     = instr_count_q;

    // Next-state logic: fetch handshake, decoder wait, issue handshake and redirects
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        komut_d       = komut_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;
        lat_cnt_d     = lat_cnt_q;
        gap_d         = 1'b0;
        instr_count_d = instr_count_q;
        err_code_d    = err_code_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d     = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (gap_q) begin
                    // Nothing outstanding in the bubble, so a redirect can retarget directly
                    if (bus.redir_valid) begin
                        pc_d = redir_word;
                    end
                end else if (bus.imem_ack) begin
                    if (bus.redir_valid) begin
                        pc_d         = redir_word;
                        redir_pend_d = 1'b0;
                        gap_d        = 1'b1;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_tgt_q;
                        redir_pend_d = 1'b0;
                        gap_d        = 1'b1;
                    end else begin
                        komut_d   = bus.imem_rdata;
                        lat_cnt_d = LAT_INIT;
                        state_d   = ST_DECODE;
                    end
                end else begin
                    if (bus.redir_valid) begin
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = redir_word;
                    end
`ifdef MEM_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_LAST) begin
                        state_d    = ST_HALT;
                        err_code_d = 2'd2;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end
            end

            ST_DECODE: begin
                if (bus.redir_valid) begin
                    pc_d    = redir_word;
                    state_d = ST_FETCH;
                end else if (lat_cnt_q == 4'd0) begin
                    if (bus.dec_hata) begin
                        state_d    = ST_HALT;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            ST_ISSUE: begin
                if (bus.issue_ready) begin
                    instr_count_d = instr_count_q + 32'd1;
                    pc_d          = bus.redir_valid ? redir_word : (pc_q + 32'd4);
                    state_d       = stop ? ST_IDLE : ST_FETCH;
                end else if (bus.redir_valid) begin
                    pc_d    = redir_word;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            komut_q       <= 32'h0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= 32'h0;
            lat_cnt_q     <= 4'd0;
            gap_q         <= 1'b0;
            instr_count_q <= 32'h0;
            err_code_q    <= 2'd0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            komut_q       <= komut_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
            lat_cnt_q     <= lat_cnt_d;
            gap_q         <= gap_d;
            instr_count_q <= instr_count_d;
            err_code_q    <= err_code_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_komut_issue_ctrl.sv
// Bench for komut_issue_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_komut_issue_ctrl;

    localparam int          DEC_LAT     = 2;
    localparam int          MEM_TIMEOUT = 16;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] BAD_WORD    = 32'hFFFF_FFFF;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        busy;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    komut_issue_ctrl_if bus ();

    komut_issue_ctrl #(
        .RESET_PC    (RESET_PC),
        .DEC_LAT     (DEC_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .err_code    (err_code),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Decoder stand-in: the all-ones word is the only illegal opcode
    assign bus.dec_hata = (bus.komut == BAD_WORD);

    logic [31:0] bad_addr = 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == bad_addr) return BAD_WORD;
        if (a == 32'h0)    return 32'h0000_0033;
        if (a == 32'h4)    return 32'h0010_0093;
        return {a[29:2], 4'h3};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Memory responder: acks mem_delay cycles after req is seen, garbage data otherwise
    int mem_delay = 1;
    int mem_cnt   = 0;
    always @(posedge clk) begin
        #2;
        if (!reset || !bus.imem_req || bus.imem_ack) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            mem_cnt        = 0;
        end else if (mem_cnt >= mem_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
            bus.imem_rdata = $urandom;
            mem_cnt++;
        end
    end

    // Behavioural model: phase plus cycle stamps, updated from the inputs of each cycle
    typedef enum {M_IDLE, M_FETCH, M_DEC, M_ISS, M_HALT} mphase_t;
    mphase_t     m_ph;
    logic [31:0] m_pc, m_word, m_count, m_ptgt, m_tgt;
    logic        m_pend, m_gap;
    logic [1:0]  m_err;
    int          m_ack_cyc, m_wait, cyc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph = M_IDLE; m_pc = RESET_PC; m_word = 32'h0; m_count = 32'h0;
            m_ptgt = 32'h0; m_pend = 1'b0; m_gap = 1'b0; m_err = 2'd0;
            m_ack_cyc = 0; m_wait = 0; cyc = 0;
        end else begin
            m_tgt = {bus.redir_pc[31:2], 2'b00};
            case (m_ph)
                M_IDLE: if (start) begin m_ph = M_FETCH; m_gap = 1'b0; end
                M_FETCH: begin
                    if (m_gap) begin
                        m_gap = 1'b0;
                        if (bus.redir_valid) m_pc = m_tgt;
                    end else if (bus.imem_ack) begin
                        m_wait = 0;
                        if (bus.redir_valid) begin
                            m_pc = m_tgt; m_pend = 1'b0; m_gap = 1'b1;
                        end else if (m_pend) begin
                            m_pc = m_ptgt; m_pend = 1'b0; m_gap = 1'b1;
                        end else begin
                            m_word = bus.imem_rdata; m_ph = M_DEC; m_ack_cyc = cyc;
                        end
                    end else begin
                        if (bus.redir_valid) begin m_pend = 1'b1; m_ptgt = m_tgt; end
`ifdef MEM_TIMEOUT_EN
                        m_wait++;
                        if (m_wait == MEM_TIMEOUT) begin m_ph = M_HALT; m_err = 2'd2; end
`endif
                    end
                end
                M_DEC: begin
                    if (bus.redir_valid) begin
                        m_pc = m_tgt; m_ph = M_FETCH;
                    end else if (cyc - m_ack_cyc == DEC_LAT) begin
                        if (m_word == BAD_WORD) begin m_ph = M_HALT; m_err = 2'd1; end
                        else m_ph = M_ISS;
                    end
                end
                M_ISS: begin
                    if (bus.issue_ready) begin
                        m_count = m_count + 32'd1;
                        m_pc    = bus.redir_valid ? m_tgt : m_pc + 32'd4;
                        m_ph    = stop ? M_IDLE : M_FETCH;
                    end else if (bus.redir_valid) begin
                        m_pc = m_tgt; m_ph = M_FETCH;
                    end
                end
                default: ;
            endcase
            if (m_ph != M_FETCH) m_wait = 0;
            cyc++;
        end
    end

    // Compare process: every output against the model on every cycle
    always @(negedge clk) begin
        check_output("imem_req",    {31'h0, bus.imem_req},    {31'h0, (m_ph == M_FETCH) && !m_gap});
        check_output("imem_addr",   bus.imem_addr,            m_pc);
        check_output("komut",       bus.komut,                m_word);
        check_output("issue_valid", {31'h0, bus.issue_valid}, {31'h0, m_ph == M_ISS});
        check_output("issue_pc",    bus.issue_pc,             m_pc);
        check_output("busy",        {31'h0, busy},            {31'h0, (m_ph != M_IDLE) && (m_ph != M_HALT)});
        check_output("halted",      {31'h0, halted},          {31'h0, m_ph == M_HALT});
        check_output("err_code",    {30'h0, err_code},        {30'h0, m_err});
        check_output("instr_count", instr_count,              m_count);
    end

    // Latency tracker: cycles from accepted ack to the first issue_valid cycle
    int   ncyc = 0, ack_at = 0, last_lat = -1;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        ncyc++;
        if (bus.imem_req && bus.imem_ack) ack_at = ncyc;
        if (bus.issue_valid && !prev_valid) last_lat = ncyc - ack_at;
        prev_valid = bus.issue_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic event_hit(input int kind);
        case (kind)
            0:       return !busy;
            1:       return bus.imem_req && bus.imem_ack;
            2:       return bus.imem_req;
            3:       return bus.issue_valid;
            default: return halted;
        endcase
    endfunction

    task automatic wait_event(input int kind, input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!event_hit(kind) && i < 300);
        check_output(name, {31'h0, event_hit(kind)}, 32'h1);
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_halted", {31'h0, halted}, 32'h0);
        check_output("rst_err",    {30'h0, err_code}, 32'h0);
        check_output("rst_addr",   bus.imem_addr, RESET_PC);
        check_output("rst_count",  instr_count, 32'h0);
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < 4000; i++) begin
            tick();
            start           = ($urandom_range(0, 3) == 0);
            stop            = ($urandom_range(0, 5) == 0);
            bus.issue_ready = $urandom_range(0, 1);
            bus.redir_valid = ($urandom_range(0, 11) == 0);
            bus.redir_pc    = ($urandom_range(0, 15) == 0) ? $urandom : {22'h0, 10'($urandom)};
            mem_delay       = $urandom_range(0, 3);
            if ($urandom_range(0, 63) == 0) bad_addr = {22'h0, 10'($urandom)} & ~32'h3;
            if (halted && $urandom_range(0, 7) == 0) reset = 1'b0;
            else if ($urandom_range(0, 999) == 0) reset = 1'b0;
            else reset = 1'b1;
        end
    endtask

    logic saw_valid;

    initial begin
        bus.issue_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_output("lit_rst_addr",  bus.imem_addr, 32'h0);
        check_output("lit_rst_ipc",   bus.issue_pc, 32'h0);
        check_output("lit_rst_komut", bus.komut, 32'h0);
        check_output("lit_rst_busy",  {31'h0, busy}, 32'h0);
        check_output("lit_rst_req",   {31'h0, bus.imem_req}, 32'h0);

        // Two back-to-back single fetches with 1-cycle memory
        stop = 1'b1; bus.issue_ready = 1'b1; mem_delay = 1;
        pulse_start();
        wait_event(0, "s1_idle_a");
        check_output("lit_s1_count1", instr_count, 32'd1);
        check_output("lit_s1_komut1", bus.komut, 32'h0000_0033);
        check_output("lit_s1_lat",    last_lat, DEC_LAT + 1);
        pulse_start();
        wait_event(0, "s1_idle_b");
        check_output("lit_s1_count2", instr_count, 32'd2);
        check_output("lit_s1_komut2", bus.komut, 32'h0010_0093);
        check_output("lit_s1_pc",     bus.imem_addr, 32'h8);

        // Execute stalls for five cycles
        bus.issue_ready = 1'b0;
        pulse_start();
        wait_event(3, "s2_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("lit_s2_valid", {31'h0, bus.issue_valid}, 32'h1);
            check_output("lit_s2_ipc",   bus.issue_pc, 32'h8);
            check_output("lit_s2_komut", bus.komut, 32'h0000_0023);
            check_output("lit_s2_count", instr_count, 32'd2);
        end
        tick();
        bus.issue_ready = 1'b1;
        wait_event(0, "s2_idle");
        check_output("lit_s2_count_after", instr_count, 32'd3);

        // Redirect to 0x103 in the first decode cycle
        pulse_start();
        wait_event(1, "s3_ack");
        tick();
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h103;
        tick();
        bus.redir_valid = 1'b0;
        @(negedge clk);
        check_output("lit_s3_req",   {31'h0, bus.imem_req}, 32'h1);
        check_output("lit_s3_addr",  bus.imem_addr, 32'h100);
        check_output("lit_s3_count", instr_count, 32'd3);
        wait_event(0, "s3_idle");
        check_output("lit_s3_count_after", instr_count, 32'd4);
        check_output("lit_s3_pc",          bus.imem_addr, 32'h104);

        // Redirect while the memory ack is 3 cycles late
        mem_delay = 3;
        pulse_start();
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h200;
        tick();
        bus.redir_valid = 1'b0;
        wait_event(1, "s4_ack");
        check_output("lit_s4_old_addr", bus.imem_addr, 32'h104);
        wait_event(2, "s4_req");
        check_output("lit_s4_new_addr", bus.imem_addr, 32'h200);
        check_output("lit_s4_count",    instr_count, 32'd4);
        wait_event(0, "s4_idle");
        check_output("lit_s4_count_after", instr_count, 32'd5);
        check_output("lit_s4_komut",       bus.komut, 32'h0000_0803);
        check_output("lit_s4_pc",          bus.imem_addr, 32'h204);

        // Illegal opcode halts; start is ignored until reset
        mem_delay = 1; bad_addr = 32'h204;
        pulse_start();
        saw_valid = 1'b0;
        for (int k = 0; k < 50 && !halted; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | bus.issue_valid;
        end
        check_output("lit_s5_halted", {31'h0, halted}, 32'h1);
        check_output("lit_s5_err",    {30'h0, err_code}, 32'd1);
        check_output("lit_s5_novalid", {31'h0, saw_valid}, 32'h0);
        pulse_start();
        repeat (5) @(negedge clk);
        check_output("lit_s5_still_halted", {31'h0, halted}, 32'h1);
        check_output("lit_s5_noreq",        {31'h0, bus.imem_req}, 32'h0);
        bad_addr = 32'hFFFF_FFFF;
        apply_reset();

`ifdef MEM_TIMEOUT_EN
        // No ack at all: watchdog halts after MEM_TIMEOUT request cycles
        begin
            int n_req = 0;
            mem_delay = 100000;
            pulse_start();
            for (int k = 0; k < 100 && !halted; k++) begin
                @(negedge clk);
                if (bus.imem_req) n_req++;
            end
            check_output("lit_tmo_cycles", n_req, 32'd16);
            check_output("lit_tmo_halted", {31'h0, halted}, 32'h1);
            check_output("lit_tmo_err",    {30'h0, err_code}, 32'd2);
            mem_delay = 1;
            apply_reset();
        end
`endif

        apply_stimulus();
        tick();
        reset = 1'b1; start = 1'b0; bus.redir_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
